vend_sequencer: RTL

- Control FSM for the coffee vending machine.
- Accumulates coin credit up to a programmable price, then sequences cup drop and brew.
- Returns change or a refund on completion, cancel, timeout or missing cup.
- Drives the status LEDs and the dispenser actuators; sits between the coin acceptor front-end and the dispenser hardware.

---
 rtl/vend_sequencer_if.sv | 39 +++
 rtl/vend_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/vend_sequencer_if.sv
// Coin front-end / dispenser signal bundle for the vending sequencer.
// Optional coin_reject exists only when VEND_COIN_REJECT_EN is defined.
interface vend_sequencer_if #(
    parameter int CREDIT_W = 5
);
    logic                coin_valid;
    logic [3:0]          coin_value;
    logic                cancel;
    logic                cup_present;
    logic [CREDIT_W-1:0] credit;
    logic                cup_drop;
    logic                brew_en;
    logic                change_valid;
    logic [CREDIT_W-1:0] change_amt;
    logic                led_yellow;
    logic                led_green;
    logic                busy;
`ifdef VEND_COIN_REJECT_EN
    logic                coin_reject;
`endif

    modport master (
        output coin_valid, coin_value, cancel, cup_present,
        input  credit, cup_drop, brew_en, change_valid, change_amt,
               led_yellow, led_green, busy
`ifdef VEND_COIN_REJECT_EN
        , input coin_reject
`endif
    );

    modport slave (
        input  coin_valid, coin_value, cancel, cup_present,
        output credit, cup_drop, brew_en, change_valid, change_amt,
               led_yellow, led_green, busy
`ifdef VEND_COIN_REJECT_EN
        , output coin_reject
`endif
    );
endinterface

// File: rtl/vend_sequencer.sv
// Coffee vending control FSM: credit collection, cup drop, brew, change/refund.
// Define VEND_COIN_REJECT_EN to reject (and flag) unacceptable coins instead of saturating/dropping.
module vend_sequencer #(
    parameter int PRICE          = 10,
    parameter int CREDIT_W       = 5,
    parameter int CUP_CYCLES     = 4,
    parameter int BREW_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic           clk,
    input  logic           rst,
    vend_sequencer_if.slave bus
);

    localparam int PHASE_MAX = (BREW_CYCLES > CUP_CYCLES) ? BREW_CYCLES : CUP_CYCLES;
    localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam int TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SUM_W     = ((CREDIT_W > 4) ? CREDIT_W : 4) + 1;

    localparam logic [PHASE_W-1:0]  CUP_LAST   = PHASE_W'(CUP_CYCLES - 1);
    localparam logic [PHASE_W-1:0]  BREW_LAST  = PHASE_W'(BREW_CYCLES - 1);
    localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SUM_W-1:0]    CREDIT_MAX = SUM_W'((1 << CREDIT_W) - 1);
    localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        CUP,
        BREW,
        CHANGE,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] refund_q, refund_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                vend_ok_q, vend_ok_d;

    logic                cup_drop_q, cup_drop_d;
    logic                brew_en_q, brew_en_d;
    logic                change_valid_q, change_valid_d;
    logic [CREDIT_W-1:0] change_amt_q, change_amt_d;
    logic                led_yellow_q, led_yellow_d;
    logic                led_green_q, led_green_d;
    logic                busy_q, busy_d;

    logic                coin_hit;
    logic                coin_fits;
    logic                coin_taken;
    logic [SUM_W-1:0]    coin_sum;
    logic                coin_overflow;
    logic [CREDIT_W-1:0] credit_add;
    logic [CREDIT_W-1:0] coll_credit;

    assign coin_hit      = bus.coin_valid && (bus.coin_value != 4'd0);
    assign coin_sum      = SUM_W'(credit_q) + SUM_W'(bus.coin_value);
    assign coin_overflow = (coin_sum > CREDIT_MAX);

`ifdef VEND_COIN_REJECT_EN
    logic coin_reject_q, coin_reject_d;

    // An add that would overflow is refused outright, so credit never saturates.
    assign coin_fits   = !coin_overflow;
    assign credit_add  = coin_sum[CREDIT_W-1:0];
    assign coin_reject_d = coin_hit && !coin_taken;
    assign bus.coin_reject = coin_reject_q;
`else
    assign coin_fits   = 1'b1;
    assign credit_add  = coin_overflow ? CREDIT_MAX[CREDIT_W-1:0] : coin_sum[CREDIT_W-1:0];
`endif

    assign coin_taken  = coin_hit && coin_fits && ((state_q == IDLE) || (state_q == COLLECT));
    assign coll_credit = coin_taken ? credit_add : credit_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            refund_q       <= '0;
            phase_q        <= '0;
            tmo_q          <= '0;
            vend_ok_q      <= 1'b0;
            cup_drop_q     <= 1'b0;
            brew_en_q      <= 1'b0;
            change_valid_q <= 1'b0;
            change_amt_q   <= '0;
            led_yellow_q   <= 1'b0;
            led_green_q    <= 1'b0;
            busy_q         <= 1'b0;
`ifdef VEND_COIN_REJECT_EN
            coin_reject_q  <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            refund_q       <= refund_d;
            phase_q        <= phase_d;
            tmo_q          <= tmo_d;
            vend_ok_q      <= vend_ok_d;
            cup_drop_q     <= cup_drop_d;
            brew_en_q      <= brew_en_d;
            change_valid_q <= change_valid_d;
            change_amt_q   <= change_amt_d;
            led_yellow_q   <= led_yellow_d;
            led_green_q    <= led_green_d;
            busy_q         <= busy_d;
`ifdef VEND_COIN_REJECT_EN
            coin_reject_q  <= coin_reject_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        credit_d  = credit_q;
        refund_d  = refund_q;
        phase_d   = phase_q;
        tmo_d     = tmo_q;
        vend_ok_d = vend_ok_q;

        case (state_q)
            IDLE: begin
                if (coin_taken) begin
                    credit_d = credit_add;
                    tmo_d    = '0;
                    state_d  = COLLECT;
                end
            end

            // Cancel outranks everything; a coin in the same cycle still joins the refund.
            COLLECT: begin
                credit_d = coll_credit;
                if (bus.cancel) begin
                    refund_d  = coll_credit;
                    vend_ok_d = 1'b0;
                    state_d   = CHANGE;
                end else if (credit_q >= PRICE_C) begin
                    phase_d = '0;
                    state_d = CUP;
                end else if (coin_hit) begin
                    tmo_d = '0;
                end else if (tmo_q == TMO_LAST) begin
                    refund_d  = credit_q;
                    vend_ok_d = 1'b0;
                    state_d   = CHANGE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            CUP: begin
                if (phase_q == CUP_LAST) begin
                    phase_d = '0;
                    if (bus.cup_present) begin
                        state_d = BREW;
                    end else begin
                        refund_d  = credit_q;
                        vend_ok_d = 1'b0;
                        state_d   = CHANGE;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            BREW: begin
                if (phase_q == BREW_LAST) begin
                    phase_d   = '0;
                    refund_d  = credit_q - PRICE_C;
                    vend_ok_d = 1'b1;
                    state_d   = CHANGE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            CHANGE: begin
                credit_d  = '0;
                refund_d  = '0;
                vend_ok_d = 1'b0;
                state_d   = vend_ok_q ? DONE : IDLE;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        cup_drop_d     = (state_d == CUP);
        brew_en_d      = (state_d == BREW);
        led_yellow_d   = (state_d == CUP) || (state_d == BREW);
        led_green_d    = (state_d == DONE);
        busy_d         = (state_d != IDLE) && (state_d != COLLECT);
        change_valid_d = (state_d == CHANGE) && (refund_d != '0);
        change_amt_d   = change_valid_d ? refund_d : '0;
    end

    assign bus.credit       = credit_q;
    assign bus.cup_drop     = cup_drop_q;
    assign bus.brew_en      = brew_en_q;
    assign bus.change_valid = change_valid_q;
    assign bus.change_amt   = change_amt_q;
    assign bus.led_yellow   = led_yellow_q;
    assign bus.led_green    = led_green_q;
    assign bus.busy         = busy_q;

endmodule
